// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM states, code constants, unit timing and ROM entry layout.
// The receive-side decoder imports the same package.
package morse_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MARK,
      ST_GAP,
      ST_CHAR_GAP,
      ST_WORD_GAP
   } state_t;

   localparam logic [5:0] CODE_SPACE     = 6'd36;
   localparam logic [5:0] CODE_MAX_VALID = 6'd36;

   localparam int DOT        = 1;
   localparam int DASH       = 3;
   localparam int EL_GAP     = 1;
   localparam int CHAR_GAP   = 3;
   localparam int WORD_EXTRA = 4;

   // The first element is pattern[len-1]. A set bit is a dash.
   typedef struct packed {
      logic       valid;
      logic [2:0] len;
      logic [4:0] pattern;
   } rom_entry_t;

endpackage

// File: rtl/morse_encoder_tx_if.sv
// Character handshake between a code producer and the Morse encoder.
interface morse_encoder_tx_if;
   logic       char_valid;
   logic [5:0] char_code;
   logic       char_ready;

   modport master (output char_valid, output char_code, input char_ready);
   modport slave  (input char_valid, input char_code, output char_ready);
endinterface

// File: rtl/morse_rom.sv
// Combinational lookup from a character code to its Morse element pattern.
// Code 36 (word space) is valid with len 0. Codes 37 to 63 are invalid.
module morse_rom
   import morse_pkg::*;
(
   input  logic [5:0] char_code,
   output rom_entry_t entry
);

   always_comb begin
      entry = '0;
      case (char_code)
         6'd0:  entry = {1'b1, 3'd5, 5'b11111};
         6'd1:  entry = {1'b1, 3'd5, 5'b01111};
         6'd2:  entry = {1'b1, 3'd5, 5'b00111};
         6'd3:  entry = {1'b1, 3'd5, 5'b00011};
         6'd4:  entry = {1'b1, 3'd5, 5'b00001};
         6'd5:  entry = {1'b1, 3'd5, 5'b00000};
         6'd6:  entry = {1'b1, 3'd5, 5'b10000};
         6'd7:  entry = {1'b1, 3'd5, 5'b11000};
         6'd8:  entry = {1'b1, 3'd5, 5'b11100};
         6'd9:  entry = {1'b1, 3'd5, 5'b11110};
         6'd10: entry = {1'b1, 3'd2, 5'b00001};
         6'd11: entry = {1'b1, 3'd4, 5'b01000};
         6'd12: entry = {1'b1, 3'd4, 5'b01010};
         6'd13: entry = {1'b1, 3'd3, 5'b00100};
         6'd14: entry = {1'b1, 3'd1, 5'b00000};
         6'd15: entry = {1'b1, 3'd4, 5'b00010};
         6'd16: entry = {1'b1, 3'd3, 5'b00110};
         6'd17: entry = {1'b1, 3'd4, 5'b00000};
         6'd18: entry = {1'b1, 3'd2, 5'b00000};
         6'd19: entry = {1'b1, 3'd4, 5'b00111};
         6'd20: entry = {1'b1, 3'd3, 5'b00101};
         6'd21: entry = {1'b1, 3'd4, 5'b00100};
         6'd22: entry = {1'b1, 3'd2, 5'b00011};
         6'd23: entry = {1'b1, 3'd2, 5'b00010};
         6'd24: entry = {1'b1, 3'd3, 5'b00111};
         6'd25: entry = {1'b1, 3'd4, 5'b00110};
         6'd26: entry = {1'b1, 3'd4, 5'b01101};
         6'd27: entry = {1'b1, 3'd3, 5'b00010};
         6'd28: entry = {1'b1, 3'd3, 5'b00000};
         6'd29: entry = {1'b1, 3'd1, 5'b00001};
         6'd30: entry = {1'b1, 3'd3, 5'b00001};
         6'd31: entry = {1'b1, 3'd4, 5'b00001};
         6'd32: entry = {1'b1, 3'd3, 5'b00011};
         6'd33: entry = {1'b1, 3'd4, 5'b01001};
         6'd34: entry = {1'b1, 3'd4, 5'b01011};
         6'd35: entry = {1'b1, 3'd4, 5'b01100};
         6'd36: entry = {1'b1, 3'd0, 5'b00000};
         default: entry = '0;
      endcase
   end

endmodule

// File: rtl/morse_encoder_tx.sv
// Morse transmitter: accepts one character code per handshake and keys it out as
// unit-timed marks and spaces on key_out. All outputs are registered.
module morse_encoder_tx
   import morse_pkg::*;
#(
   parameter int UNIT_CYCLES = 1000
) (
   input  logic               clk,
   input  logic               rst,
   morse_encoder_tx_if.slave  bus,
   output logic               key_out,
   output logic               busy,
   output logic               char_done,
   output logic               err
);

   localparam int PW = (UNIT_CYCLES > 2) ? $clog2(UNIT_CYCLES) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(UNIT_CYCLES - 1);

   state_t     state, state_n;
   logic [PW-1:0] pre, pre_n;
   logic [1:0] units, units_n, mark_units;
   logic [2:0] idx, idx_n, len_q, len_n, bit_sel;
   logic [4:0] pat_q, pat_n, pat_shift;
   logic       ready_q, ready_n, key_n, busy_n, done_n, err_n;
   logic       tick, dash, gap_exit, accept;
   rom_entry_t entry;

   morse_rom u_rom (
      .char_code (bus.char_code),
      .entry     (entry)
   );

   assign tick       = (pre == PRE_MAX);
   assign bit_sel    = len_q - 3'd1 - idx;
   assign pat_shift  = pat_q >> bit_sel;
   assign dash       = pat_shift[0];
   assign mark_units = dash ? 2'(DASH - 1) : 2'(DOT - 1);
   assign bus.char_ready = ready_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         pre       <= '0;
         units     <= '0;
         idx       <= '0;
         len_q     <= '0;
         pat_q     <= '0;
         ready_q   <= 1'b0;
         key_out   <= 1'b0;
         busy      <= 1'b0;
         char_done <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_n;
         pre       <= pre_n;
         units     <= units_n;
         idx       <= idx_n;
         len_q     <= len_n;
         pat_q     <= pat_n;
         ready_q   <= ready_n;
         key_out   <= key_n;
         busy      <= busy_n;
         char_done <= done_n;
         err       <= err_n;
      end
   end

   // Timing counters restart on every state change so each state lasts a whole number of units.
   always_comb begin
      state_n  = state;
      pre_n    = tick ? '0 : pre + PW'(1);
      units_n  = tick ? units + 2'd1 : units;
      idx_n    = idx;
      len_n    = len_q;
      pat_n    = pat_q;
      ready_n  = 1'b0;
      key_n    = 1'b0;
      busy_n   = busy;
      done_n   = 1'b0;
      err_n    = 1'b0;
      gap_exit = 1'b0;
      accept   = 1'b0;

      case (state)
         ST_IDLE: begin
            busy_n  = 1'b0;
            ready_n = 1'b1;
            pre_n   = '0;
            units_n = '0;
         end
         ST_MARK: begin
            key_n = 1'b1;
            if (tick && units == mark_units) begin
               key_n   = 1'b0;
               pre_n   = '0;
               units_n = '0;
               if (idx + 3'd1 < len_q) begin
                  state_n = ST_GAP;
                  idx_n   = idx + 3'd1;
               end else begin
                  state_n = ST_CHAR_GAP;
                  idx_n   = '0;
               end
            end
         end
         ST_GAP: begin
            if (tick && units == 2'(EL_GAP - 1)) begin
               state_n = ST_MARK;
               key_n   = 1'b1;
               pre_n   = '0;
               units_n = '0;
            end
         end
         ST_CHAR_GAP: gap_exit = tick && units == 2'(CHAR_GAP - 1);
         ST_WORD_GAP: gap_exit = tick && units == 2'(WORD_EXTRA - 1);
         default:     state_n = ST_IDLE;
      endcase

      if (gap_exit) begin
         state_n = ST_IDLE;
         done_n  = 1'b1;
         busy_n  = 1'b0;
         ready_n = 1'b1;
         pre_n   = '0;
         units_n = '0;
      end

      // A held char_valid is taken on the same edge a gap finishes, so no idle bubble appears.
      accept = bus.char_valid && ((state == ST_IDLE && ready_q) || gap_exit);

      if (accept) begin
         pre_n   = '0;
         units_n = '0;
         idx_n   = '0;
         ready_n = 1'b0;
         if (bus.char_code == CODE_SPACE) begin
            state_n = ST_WORD_GAP;
            busy_n  = 1'b1;
         end else if (entry.valid && bus.char_code <= CODE_MAX_VALID) begin
            state_n = ST_MARK;
            key_n   = 1'b1;
            busy_n  = 1'b1;
            len_n   = entry.len;
            pat_n   = entry.pattern;
         end else begin
            state_n = ST_IDLE;
            err_n   = 1'b1;
            busy_n  = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_morse_encoder_tx.sv
// Directed bench for morse_encoder_tx with UNIT_CYCLES=4 (dot = 4 cycles, dash = 12).
module tb_morse_encoder_tx;

   logic clk = 1'b0;
   logic rst;
   logic key_out, busy, char_done, err;
   int   compared   = 0;
   int   mismatched = 0;

   morse_encoder_tx_if bus ();

   morse_encoder_tx #(.UNIT_CYCLES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .key_out   (key_out),
      .busy      (busy),
      .char_done (char_done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Steps n cycles while a character is in flight, expecting key_out at lvl.
   task automatic expect_run(input string tag, input logic lvl, input int n);
      for (int i = 0; i < n; i++) begin
         check_output($sformatf("%s/key[%0d]", tag, i), key_out, lvl);
         check_output($sformatf("%s/ready[%0d]", tag, i), bus.char_ready, 1'b0);
         check_output($sformatf("%s/busy[%0d]", tag, i), busy, 1'b1);
         check_output($sformatf("%s/done[%0d]", tag, i), char_done, 1'b0);
         step();
      end
   endtask

   task automatic apply_stimulus(input logic [5:0] code);
      bus.char_valid = 1'b1;
      bus.char_code  = code;
      step();
      bus.char_valid = 1'b0;
   endtask

   task automatic expect_done(input string tag);
      check_output({tag, "/done"}, char_done, 1'b1);
      check_output({tag, "/ready"}, bus.char_ready, 1'b1);
      check_output({tag, "/busy"}, busy, 1'b0);
      check_output({tag, "/key"}, key_out, 1'b0);
      step();
      check_output({tag, "/done_pulse"}, char_done, 1'b0);
   endtask

   initial begin
      rst            = 1'b1;
      bus.char_valid = 1'b0;
      bus.char_code  = 6'd0;
      step();
      step();
      check_output("reset/key", key_out, 1'b0);
      check_output("reset/ready", bus.char_ready, 1'b0);
      check_output("reset/busy", busy, 1'b0);
      check_output("reset/done", char_done, 1'b0);
      check_output("reset/err", err, 1'b0);
      rst = 1'b0;
      step();
      check_output("release/ready", bus.char_ready, 1'b1);

      // 'E': one dot then the 3-unit character gap
      apply_stimulus(6'd14);
      expect_run("E", 1'b1, 4);
      expect_run("E", 1'b0, 12);
      expect_done("E");

      // 'A': dot, gap, dash, character gap
      check_output("A/ready_pre", bus.char_ready, 1'b1);
      apply_stimulus(6'd10);
      expect_run("A", 1'b1, 4);
      expect_run("A", 1'b0, 4);
      expect_run("A", 1'b1, 12);
      expect_run("A", 1'b0, 12);
      expect_done("A");

      // '0': five dashes
      apply_stimulus(6'd0);
      for (int e = 0; e < 5; e++) begin
         expect_run($sformatf("zero_m%0d", e), 1'b1, 12);
         if (e < 4) expect_run($sformatf("zero_g%0d", e), 1'b0, 4);
      end
      expect_run("zero_cg", 1'b0, 12);
      expect_done("zero");

      // 'E', word space, 'E' with char_valid held throughout
      bus.char_valid = 1'b1;
      bus.char_code  = 6'd14;
      step();
      bus.char_code  = 6'd36;
      expect_run("b2b_E", 1'b1, 4);
      expect_run("b2b_E", 1'b0, 12);
      check_output("b2b_sp/done", char_done, 1'b1);
      check_output("b2b_sp/busy", busy, 1'b1);
      check_output("b2b_sp/ready", bus.char_ready, 1'b0);
      check_output("b2b_sp/key", key_out, 1'b0);
      bus.char_code = 6'd14;
      step();
      expect_run("b2b_word", 1'b0, 15);
      check_output("b2b_E2/done", char_done, 1'b1);
      check_output("b2b_E2/key", key_out, 1'b1);
      check_output("b2b_E2/busy", busy, 1'b1);
      check_output("b2b_E2/ready", bus.char_ready, 1'b0);
      bus.char_valid = 1'b0;
      step();
      expect_run("b2b_E2", 1'b1, 3);
      expect_run("b2b_E2", 1'b0, 12);
      expect_done("b2b_E2");

      // Invalid code 45 is dropped with a one-cycle err pulse
      apply_stimulus(6'd45);
      check_output("inv/err", err, 1'b1);
      check_output("inv/ready", bus.char_ready, 1'b0);
      check_output("inv/key", key_out, 1'b0);
      check_output("inv/busy", busy, 1'b0);
      step();
      check_output("inv/err_pulse", err, 1'b0);
      check_output("inv/ready2", bus.char_ready, 1'b1);
      for (int i = 0; i < 20; i++) begin
         check_output($sformatf("inv/nodone[%0d]", i), char_done, 1'b0);
         check_output($sformatf("inv/nokey[%0d]", i), key_out, 1'b0);
         step();
      end

      // Reset in the middle of the dash of 'A'
      apply_stimulus(6'd10);
      expect_run("rstA", 1'b1, 4);
      expect_run("rstA", 1'b0, 4);
      expect_run("rstA", 1'b1, 5);
      rst = 1'b1;
      step();
      check_output("rstA/key", key_out, 1'b0);
      check_output("rstA/ready", bus.char_ready, 1'b0);
      check_output("rstA/busy", busy, 1'b0);
      rst = 1'b0;
      step();
      check_output("rstA/ready_rel", bus.char_ready, 1'b1);
      check_output("rstA/key_rel", key_out, 1'b0);
      apply_stimulus(6'd14);
      expect_run("postrst_E", 1'b1, 4);
      expect_run("postrst_E", 1'b0, 12);
      expect_done("postrst_E");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
